cro_ctrl: RTL and testbench

Run/lap controller for the chronometer datapath. It conditions two raw push-buttons (start/stop, lap/clear) and generates the 100 Hz timebase. A four-state machine then issues count-enable, clear, lap-capture and display-select strobes to the BCD counter chain and the 7-segment scanner. It sits between the board inputs and the counter/display logic, replacing the ad-hoc start/stop flip-flop with a sequenced controller.

---
 rtl/cro_ctrl_if.sv | 24 ++
 rtl/cro_ctrl.sv | 167 ++++++++++++++++
 tb/tb_cro_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cro_ctrl_if.sv
// Board/counter-side signal bundle of the chronometer run/lap controller.
// The master side is the controller. It receives the raw buttons and drives the strobes.
// The slave side is the board and the counter/display logic.
interface cro_ctrl_if;
    logic       btn_ss;
    logic       btn_lap;
    logic       tick;
    logic       cnt_en;
    logic       cnt_clr;
    logic       lap_load;
    logic       disp_sel;
    logic       running;
    logic [1:0] state;

    modport master (
        input  btn_ss, btn_lap,
        output tick, cnt_en, cnt_clr, lap_load, disp_sel, running, state
    );

    modport slave (
        output btn_ss, btn_lap,
        input  tick, cnt_en, cnt_clr, lap_load, disp_sel, running, state
    );
endinterface

// File: rtl/cro_ctrl.sv
// Chronometer run/lap controller.
// It conditions the start/stop and lap/clear buttons, generates the 100 Hz tick,
// and sequences count, clear, lap-capture and display-select strobes.
module cro_ctrl #(
    parameter int TICK_DIV   = 500000,
    parameter int HOLD_TICKS = 5,
    parameter int LAP_SHOW   = 300
) (
    input  logic      clk,
    input  logic      rst_n,
    cro_ctrl_if.master bus
);
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam int LW = $clog2(LAP_SHOW + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS);
    localparam logic [LW-1:0] LAP_LOAD  = LW'(LAP_SHOW);
    localparam logic [LW-1:0] LAP_ONE   = LW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STOP = 2'b10,
        LAP  = 2'b11
    } state_t;

    logic [DW-1:0]        div_q, div_d;
    logic                 tick_q, tick_d;
    logic [1:0]           sync1_q, sync1_d;
    logic [1:0]           sync2_q, sync2_d;
    logic [1:0][HW-1:0]   hold_q, hold_d;
    logic [1:0]           pressed;
    logic [1:0]           pressed_r_q, pressed_r_d;
    logic [1:0]           ev;
    state_t               state_q, state_d;
    logic [LW-1:0]        lap_q, lap_d;
    logic                 clr_q, clr_d;
    logic                 load_q, load_d;

    // Free-running divider; tick fires the cycle after the last count
    always_comb begin
        div_d  = div_q + 1'b1;
        tick_d = 1'b0;
        if (div_q == DIV_LAST) begin
            div_d  = '0;
            tick_d = 1'b1;
        end
    end

    // Synchronize both buttons (bit 0 = start/stop, bit 1 = lap/clear) and stretch releases by HOLD_TICKS ticks
    always_comb begin
        sync1_d = {bus.btn_lap, bus.btn_ss};
        sync2_d = sync1_q;
        for (int i = 0; i < 2; i++) begin
            hold_d[i] = hold_q[i];
            if (sync2_q[i]) begin
                hold_d[i] = HOLD_LOAD;
            end else if (tick_q && (hold_q[i] != '0)) begin
                hold_d[i] = hold_q[i] - 1'b1;
            end
            pressed[i] = (hold_q[i] != '0);
        end
        pressed_r_d = pressed;
        ev          = pressed & ~pressed_r_q;
    end

    // Next state, lap display timer and one-cycle clear/capture strobes; start/stop beats lap
    always_comb begin
        state_d = state_q;
        lap_d   = lap_q;
        clr_d   = 1'b0;
        load_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ev[0]) begin
                    state_d = RUN;
                end else if (ev[1]) begin
                    clr_d = 1'b1;
                end
            end
            RUN: begin
                if (ev[0]) begin
                    state_d = STOP;
                end else if (ev[1]) begin
                    state_d = LAP;
                    lap_d   = LAP_LOAD;
                    load_d  = 1'b1;
                end
            end
            LAP: begin
                if (ev[0]) begin
                    state_d = STOP;
                    lap_d   = '0;
                end else if (ev[1]) begin
                    lap_d  = LAP_LOAD;
                    load_d = 1'b1;
                end else if (tick_q) begin
                    if ((lap_q == '0) || (lap_q == LAP_ONE)) begin
                        state_d = RUN;
                        lap_d   = '0;
                    end else begin
                        lap_d = lap_q - 1'b1;
                    end
                end
            end
            STOP: begin
                if (ev[0]) begin
                    state_d = RUN;
                end else if (ev[1]) begin
                    state_d = IDLE;
                    clr_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Timebase registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    // Button conditioning registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            hold_q      <= '0;
            pressed_r_q <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            hold_q      <= hold_d;
            pressed_r_q <= pressed_r_d;
        end
    end

    // State register, lap timer and strobe flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lap_q   <= '0;
            clr_q   <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lap_q   <= lap_d;
            clr_q   <= clr_d;
            load_q  <= load_d;
        end
    end

    assign bus.tick     = tick_q;
    assign bus.cnt_en   = tick_q & ((state_q == RUN) || (state_q == LAP));
    assign bus.cnt_clr  = clr_q;
    assign bus.lap_load = load_q;
    assign bus.disp_sel = (state_q == LAP);
    assign bus.running  = state_q[0] | (state_q == LAP);
    assign bus.state    = state_q;
endmodule

// File: tb/tb_cro_ctrl.sv
// Directed testbench for the chronometer run/lap controller.
// Uses TICK_DIV=10, HOLD_TICKS=2, LAP_SHOW=4.
module tb_cro_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    cro_ctrl_if bus_if ();

    cro_ctrl #(
        .TICK_DIV  (10),
        .HOLD_TICKS(2),
        .LAP_SHOW  (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if.master)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    bit         exp_tick = 1'b0;
    int         n_en = 0, n_clr = 0, n_load = 0, n_trans = 0;
    logic [1:0] prev_state = 2'b00;

    // Advance to the next falling edge and tally the observed strobes
    task automatic step();
        @(negedge clk);
        cyc++;
        exp_tick = (cyc % 10 == 0);
        if (bus_if.cnt_en === 1'b1) n_en++;
        if (bus_if.cnt_clr === 1'b1) n_clr++;
        if (bus_if.lap_load === 1'b1) n_load++;
        if (bus_if.state !== prev_state) n_trans++;
        prev_state = bus_if.state;
    endtask

    // Hold the selected buttons high for three cycles, then return one cycle after release
    task automatic press(input bit ss, input bit lap);
        bus_if.btn_ss  = ss;
        bus_if.btn_lap = lap;
        repeat (3) step();
        bus_if.btn_ss  = 1'b0;
        bus_if.btn_lap = 1'b0;
        step();
    endtask

    task automatic test_reset();
        bus_if.btn_ss  = 1'b0;
        bus_if.btn_lap = 1'b0;
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({bus_if.state, bus_if.tick, bus_if.cnt_en, bus_if.cnt_clr, bus_if.lap_load,
             bus_if.disp_sel, bus_if.running} !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got state=%b tick=%b en=%b clr=%b load=%b sel=%b run=%b required all 0",
                     bus_if.state, bus_if.tick, bus_if.cnt_en, bus_if.cnt_clr, bus_if.lap_load,
                     bus_if.disp_sel, bus_if.running);
        end
        rst_n = 1'b1;
        cyc = 0;
        prev_state = bus_if.state;
        for (int i = 1; i <= 20; i++) begin
            step();
            checks++;
            if (bus_if.tick !== ((i % 10) == 0)) begin
                errors++;
                $display("[TB] FAIL idle_tick cycle %0d: got %b required %b", i, bus_if.tick, (i % 10) == 0);
            end
            checks++;
            if ({bus_if.state, bus_if.cnt_en, bus_if.cnt_clr, bus_if.lap_load, bus_if.disp_sel, bus_if.running} !== 7'h00) begin
                errors++;
                $display("[TB] FAIL idle_outputs cycle %0d: got state=%b en=%b clr=%b load=%b sel=%b run=%b required all 0",
                         i, bus_if.state, bus_if.cnt_en, bus_if.cnt_clr, bus_if.lap_load, bus_if.disp_sel, bus_if.running);
            end
        end
    endtask

    task automatic test_start_stop();
        int en0;
        bus_if.btn_ss = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (bus_if.state !== 2'b00) begin
                errors++;
                $display("[TB] FAIL ss_latency_early step %0d: got %b required 00", i, bus_if.state);
            end
        end
        bus_if.btn_ss = 1'b0;
        step();
        checks++;
        if (bus_if.state !== 2'b01 || bus_if.running !== 1'b1 || bus_if.disp_sel !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ss_start: got state=%b run=%b sel=%b required 01/1/0", bus_if.state, bus_if.running, bus_if.disp_sel);
        end
        en0 = n_en;
        for (int i = 0; i < 30; i++) begin
            step();
            checks++;
            if (bus_if.cnt_en !== exp_tick || bus_if.state !== 2'b01) begin
                errors++;
                $display("[TB] FAIL run_cnt_en cyc %0d: got en=%b state=%b required en=%b state=01", cyc, bus_if.cnt_en, bus_if.state, exp_tick);
            end
        end
        checks++;
        if (n_en - en0 != 3) begin
            errors++;
            $display("[TB] FAIL run_en_count: got %0d required 3", n_en - en0);
        end
        press(1'b1, 1'b0);
        checks++;
        if (bus_if.state !== 2'b10 || bus_if.running !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ss_stop: got state=%b run=%b required 10/0", bus_if.state, bus_if.running);
        end
        for (int i = 0; i < 30; i++) begin
            step();
            checks++;
            if (bus_if.cnt_en !== 1'b0 || bus_if.state !== 2'b10) begin
                errors++;
                $display("[TB] FAIL stop_quiet cyc %0d: got en=%b state=%b required 0/10", cyc, bus_if.cnt_en, bus_if.state);
            end
        end
    endtask

    task automatic test_bounce();
        int t0;
        t0 = n_trans;
        for (int i = 0; i < 8; i++) begin
            bus_if.btn_ss = ((i % 2) == 0);
            step();
        end
        bus_if.btn_ss = 1'b0;
        repeat (3) step();
        bus_if.btn_ss = 1'b1;
        repeat (3) step();
        bus_if.btn_ss = 1'b0;
        repeat (40) step();
        checks++;
        if (n_trans - t0 != 1) begin
            errors++;
            $display("[TB] FAIL bounce_transitions: got %0d required 1", n_trans - t0);
        end
        checks++;
        if (bus_if.state !== 2'b01) begin
            errors++;
            $display("[TB] FAIL bounce_state: got %b required 01", bus_if.state);
        end
    endtask

    task automatic test_lap();
        int l0, lap_ticks, guard;
        logic [1:0] exp_st;
        l0 = n_load;
        press(1'b0, 1'b1);
        checks++;
        if (bus_if.lap_load !== 1'b1 || bus_if.state !== 2'b11 || bus_if.disp_sel !== 1'b1 || bus_if.running !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lap_enter: got load=%b state=%b sel=%b run=%b required 1/11/1/1",
                     bus_if.lap_load, bus_if.state, bus_if.disp_sel, bus_if.running);
        end
        lap_ticks = exp_tick ? 1 : 0;
        guard = 0;
        while (lap_ticks < 3 && guard < 40) begin
            step();
            guard++;
            checks++;
            if (bus_if.state !== 2'b11 || bus_if.cnt_en !== exp_tick) begin
                errors++;
                $display("[TB] FAIL lap_hold cyc %0d: got state=%b en=%b required 11/%b", cyc, bus_if.state, bus_if.cnt_en, exp_tick);
            end
            if (exp_tick) lap_ticks++;
        end
        checks++;
        if (lap_ticks != 3) begin
            errors++;
            $display("[TB] FAIL lap_tick_timeout: got %0d ticks required 3", lap_ticks);
        end
        repeat (2) step();
        press(1'b0, 1'b1);
        checks++;
        if (bus_if.lap_load !== 1'b1 || bus_if.state !== 2'b11) begin
            errors++;
            $display("[TB] FAIL lap_reload: got load=%b state=%b required 1/11", bus_if.lap_load, bus_if.state);
        end
        lap_ticks = exp_tick ? 1 : 0;
        for (int i = 0; i < 60; i++) begin
            step();
            exp_st = (lap_ticks >= 4) ? 2'b01 : 2'b11;
            checks++;
            if (bus_if.state !== exp_st || bus_if.disp_sel !== (lap_ticks < 4) ||
                bus_if.cnt_en !== exp_tick || bus_if.lap_load !== 1'b0) begin
                errors++;
                $display("[TB] FAIL lap_window cyc %0d: got state=%b sel=%b en=%b load=%b required %b/%b/%b/0",
                         cyc, bus_if.state, bus_if.disp_sel, bus_if.cnt_en, bus_if.lap_load, exp_st, lap_ticks < 4, exp_tick);
            end
            if (exp_tick) lap_ticks++;
        end
        checks++;
        if (n_load - l0 != 2) begin
            errors++;
            $display("[TB] FAIL lap_load_count: got %0d required 2", n_load - l0);
        end
    endtask

    task automatic test_clear();
        int c0;
        press(1'b1, 1'b0);
        checks++;
        if (bus_if.state !== 2'b10) begin
            errors++;
            $display("[TB] FAIL clear_pre_stop: got %b required 10", bus_if.state);
        end
        repeat (30) step();
        c0 = n_clr;
        press(1'b0, 1'b1);
        checks++;
        if (bus_if.cnt_clr !== 1'b1 || bus_if.state !== 2'b00) begin
            errors++;
            $display("[TB] FAIL clear_from_stop: got clr=%b state=%b required 1/00", bus_if.cnt_clr, bus_if.state);
        end
        step();
        checks++;
        if (bus_if.cnt_clr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_pulse_width: got %b required 0", bus_if.cnt_clr);
        end
        repeat (30) step();
        press(1'b0, 1'b1);
        checks++;
        if (bus_if.cnt_clr !== 1'b1 || bus_if.state !== 2'b00) begin
            errors++;
            $display("[TB] FAIL clear_in_idle: got clr=%b state=%b required 1/00", bus_if.cnt_clr, bus_if.state);
        end
        repeat (30) step();
        checks++;
        if (n_clr - c0 != 2) begin
            errors++;
            $display("[TB] FAIL clear_count: got %0d required 2", n_clr - c0);
        end
    endtask

    task automatic test_simultaneous();
        int l0, c0;
        press(1'b1, 1'b0);
        checks++;
        if (bus_if.state !== 2'b01) begin
            errors++;
            $display("[TB] FAIL simul_pre_run: got %b required 01", bus_if.state);
        end
        repeat (30) step();
        l0 = n_load;
        c0 = n_clr;
        press(1'b1, 1'b1);
        checks++;
        if (bus_if.state !== 2'b10 || bus_if.lap_load !== 1'b0) begin
            errors++;
            $display("[TB] FAIL simul_state: got state=%b load=%b required 10/0", bus_if.state, bus_if.lap_load);
        end
        repeat (30) step();
        checks++;
        if (n_load != l0 || n_clr != c0 || bus_if.state !== 2'b10) begin
            errors++;
            $display("[TB] FAIL simul_discard: got loads=%0d clrs=%0d state=%b required 0/0/10", n_load - l0, n_clr - c0, bus_if.state);
        end
    endtask

    task automatic test_reset_mid_lap();
        int c0;
        press(1'b1, 1'b0);
        repeat (30) step();
        press(1'b0, 1'b1);
        checks++;
        if (bus_if.state !== 2'b11) begin
            errors++;
            $display("[TB] FAIL rst_pre_lap: got %b required 11", bus_if.state);
        end
        repeat (2) step();
        c0 = n_clr;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_if.state, bus_if.disp_sel, bus_if.running, bus_if.cnt_clr, bus_if.lap_load, bus_if.cnt_en, bus_if.tick} !== 8'h00) begin
            errors++;
            $display("[TB] FAIL rst_async: got state=%b sel=%b run=%b clr=%b load=%b en=%b tick=%b required all 0",
                     bus_if.state, bus_if.disp_sel, bus_if.running, bus_if.cnt_clr, bus_if.lap_load, bus_if.cnt_en, bus_if.tick);
        end
        step();
        rst_n = 1'b1;
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            checks++;
            if (bus_if.tick !== exp_tick || bus_if.state !== 2'b00 || bus_if.cnt_clr !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rst_after cycle %0d: got tick=%b state=%b clr=%b required %b/00/0",
                         i, bus_if.tick, bus_if.state, bus_if.cnt_clr, exp_tick);
            end
        end
        checks++;
        if (n_clr != c0) begin
            errors++;
            $display("[TB] FAIL rst_no_clr: got %0d pulses required 0", n_clr - c0);
        end
    endtask

    // Run every scenario in order and report the totals
    initial begin
        bus_if.btn_ss  = 1'b0;
        bus_if.btn_lap = 1'b0;
        test_reset();
        test_start_stop();
        test_bounce();
        test_lap();
        test_clear();
        test_simultaneous();
        test_reset_mid_lap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
